// File: rtl/async_fifo_rd_stream.sv
// Read-side drain engine for async_fifo: pops FIFO words into a 4-entry skid buffer and
// presents them as a valid/ready stream with a running delivered-word count.
module async_fifo_rd_stream #(
  parameter int unsigned DSIZE      = 8,
  parameter int unsigned RD_LATENCY = 0,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               rclk,
  input  logic               rrst,
  output logic               rreq,
  input  logic               rempty,
  input  logic [DSIZE-1:0]   rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DSIZE-1:0]   m_data,
  output logic [COUNT_W-1:0] rd_count,
  output logic               idle
);

  logic [DSIZE-1:0]   mem_q [4];
  logic [DSIZE-1:0]   mem_d [4];
  logic [1:0]         head_q, head_d;
  logic [1:0]         tail_q, tail_d;
  logic [2:0]         occ_q, occ_d;
  logic               inflight_q, inflight_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               cap;
  logic               pop;

  always_comb begin
    // Reserve a slot for every word already requested so the buffer can never overflow.
    rreq       = !rrst && !rempty && ((occ_q + {2'b00, inflight_q}) < 3'd4);
    cap        = (RD_LATENCY == 0) ? rreq : inflight_q;
    inflight_d = (RD_LATENCY == 0) ? 1'b0 : rreq;

    m_valid  = (occ_q != 3'd0);
    m_data   = mem_q[head_q];
    pop      = m_valid && m_ready;
    rd_count = count_q;
    idle     = (occ_q == 3'd0) && !inflight_q && rempty;

    mem_d = mem_q;
    if (cap) begin
      mem_d[tail_q] = rdata;
    end
    tail_d  = tail_q + 2'(cap);
    head_d  = head_q + 2'(pop);
    occ_d   = occ_q + 3'(cap) - 3'(pop);
    count_d = count_q + COUNT_W'(pop);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Directed bench: three lanes (latency 0, latency 1, 4-bit counter), each fed by a FIFO model.
module tb_async_fifo_rd_stream;

  logic       clk = 1'b0;
  logic [2:0] rrst;
  logic [2:0] rreq;
  logic [2:0] rempty;
  logic [2:0] m_valid;
  logic [2:0] m_ready;
  logic [2:0] idle;
  logic [7:0] rdata [3];
  logic [7:0] m_data [3];
  logic [15:0] rd_count [3];
  logic [3:0] rd_count_w;
  logic [7:0] rdata1_q = 8'd0;

  logic [7:0] fmem [3][256];
  int wp [3];
  int rp [3];
  int exp_idx [3];
  int cnt [3];
  int errs = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  async_fifo_rd_stream #(.DSIZE(8), .RD_LATENCY(0), .COUNT_W(16)) dut0 (
    .rclk(clk), .rrst(rrst[0]), .rreq(rreq[0]), .rempty(rempty[0]), .rdata(rdata[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .rd_count(rd_count[0]),
    .idle(idle[0])
  );
  async_fifo_rd_stream #(.DSIZE(8), .RD_LATENCY(1), .COUNT_W(16)) dut1 (
    .rclk(clk), .rrst(rrst[1]), .rreq(rreq[1]), .rempty(rempty[1]), .rdata(rdata[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .rd_count(rd_count[1]),
    .idle(idle[1])
  );
  async_fifo_rd_stream #(.DSIZE(8), .RD_LATENCY(0), .COUNT_W(4)) dut2 (
    .rclk(clk), .rrst(rrst[2]), .rreq(rreq[2]), .rempty(rempty[2]), .rdata(rdata[2]),
    .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]), .rd_count(rd_count_w),
    .idle(idle[2])
  );

  assign rd_count[2] = {12'd0, rd_count_w};
  assign rempty[0] = (wp[0] == rp[0]);
  assign rempty[1] = (wp[1] == rp[1]);
  assign rempty[2] = (wp[2] == rp[2]);
  // Lanes 0/2 are show-ahead; lane 1 returns data one cycle after the request.
  assign rdata[0] = fmem[0][rp[0][7:0]];
  assign rdata[1] = rdata1_q;
  assign rdata[2] = fmem[2][rp[2][7:0]];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rreq[k]) rp[k] <= rp[k] + 1;
    end
    if (rreq[1]) rdata1_q <= fmem[1][rp[1][7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push(input int k, input int num);
    for (int i = 0; i < num; i++) begin
      fmem[k][wp[k][7:0]] = 8'(wp[k] + 1);
      wp[k] = wp[k] + 1;
    end
  endtask

  // Per-cycle model check, evaluated just before the posedge that acts on current inputs.
  task automatic look();
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] cexp;
      cexp = (k == 2) ? 16'(cnt[k] & 15) : 16'(cnt[k]);
      chk($sformatf("rreq_while_empty%0d", k), {31'd0, rreq[k] & rempty[k]}, 32'd0);
      chk($sformatf("rd_count%0d", k), {16'd0, rd_count[k]}, {16'd0, cexp});
      chk($sformatf("outstanding%0d", k), {31'd0, (rp[k] - exp_idx[k]) <= 4}, 32'd1);
      if (rrst[k]) begin
        chk($sformatf("rreq_in_reset%0d", k), {31'd0, rreq[k]}, 32'd0);
        cnt[k] = 0;
        exp_idx[k] = rp[k];
      end else if (m_valid[k] && m_ready[k]) begin
        chk($sformatf("data%0d", k), {24'd0, m_data[k]}, 32'(8'(exp_idx[k] + 1)));
        exp_idx[k] = exp_idx[k] + 1;
        cnt[k] = cnt[k] + 1;
      end
    end
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic cyc();
    look();
    adv();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      wp[k] = 0; exp_idx[k] = 0; cnt[k] = 0;
    end
    rrst = 3'b111;
    m_ready = 3'b111;
    @(negedge clk);
    cyc();
    cyc();
    rrst = 3'b000;

    // Reset state; m_ready high with nothing valid must not count.
    look();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), {31'd0, m_valid[k]}, 32'd0);
      chk($sformatf("rst_data%0d", k), {24'd0, m_data[k]}, 32'd0);
      chk($sformatf("rst_idle%0d", k), {31'd0, idle[k]}, 32'd1);
      chk($sformatf("rst_rreq%0d", k), {31'd0, rreq[k]}, 32'd0);
    end
    adv();
    cyc();

    // Streaming 1..16 on lanes 0/1, 1..17 on lane 2, m_ready held high.
    push(0, 16); push(1, 16); push(2, 17);
    look();
    chk("first_rreq0", {31'd0, rreq[0]}, 32'd1);
    chk("first_rreq1", {31'd0, rreq[1]}, 32'd1);
    chk("first_valid0_n", {31'd0, m_valid[0]}, 32'd0);
    chk("first_valid1_n", {31'd0, m_valid[1]}, 32'd0);
    chk("busy_idle0", {31'd0, idle[0]}, 32'd0);
    adv();
    look();
    chk("lat0_valid_n1", {31'd0, m_valid[0]}, 32'd1);
    chk("lat0_data_n1", {24'd0, m_data[0]}, 32'd1);
    chk("lat1_valid_n1", {31'd0, m_valid[1]}, 32'd0);
    adv();
    look();
    chk("lat1_valid_n2", {31'd0, m_valid[1]}, 32'd1);
    chk("lat1_data_n2", {24'd0, m_data[1]}, 32'd1);
    adv();
    n = 0;
    while (!(exp_idx[0] == 16 && exp_idx[1] == 16 && exp_idx[2] == 17) && n < 40) begin
      cyc();
      n++;
    end
    chk("stream_cycles", n, 32'd15);
    look();
    chk("end_count0", {16'd0, rd_count[0]}, 32'd16);
    chk("end_count1", {16'd0, rd_count[1]}, 32'd16);
    chk("wrap_count2", {28'd0, rd_count_w}, 32'd1);
    chk("end_idle0", {31'd0, idle[0]}, 32'd1);
    chk("end_idle1", {31'd0, idle[1]}, 32'd1);
    chk("end_idle2", {31'd0, idle[2]}, 32'd1);
    adv();

    // Backpressure on lane 0: buffer fills to 4, rreq drops, head word holds.
    m_ready[0] = 1'b0;
    push(0, 16);
    for (int i = 0; i < 6; i++) begin
      look();
      if (i >= 1) begin
        chk("bp_valid", {31'd0, m_valid[0]}, 32'd1);
        chk("bp_hold", {24'd0, m_data[0]}, 32'd17);
      end
      adv();
    end
    look();
    chk("bp_rreq_low", {31'd0, rreq[0]}, 32'd0);
    chk("bp_fifo_taken", rp[0], 32'd20);
    adv();
    m_ready[0] = 1'b1;
    n = 0;
    while (exp_idx[0] != 32 && n < 40) begin
      cyc();
      n++;
    end
    chk("bp_drain_cycles", n, 32'd16);
    look();
    chk("bp_count", {16'd0, rd_count[0]}, 32'd32);
    adv();

    // Lane 1 with m_ready toggling every cycle.
    push(1, 16);
    n = 0;
    while (exp_idx[1] != 32 && n < 100) begin
      m_ready[1] = ~m_ready[1];
      cyc();
      n++;
    end
    m_ready[1] = 1'b1;
    look();
    chk("toggle_count", {16'd0, rd_count[1]}, 32'd32);
    adv();

    // Reset lane 0 mid-stream with a full buffer; discarded words must not reappear.
    push(0, 16);
    n = 0;
    while (exp_idx[0] != 37 && n < 40) begin
      cyc();
      n++;
    end
    m_ready[0] = 1'b0;
    cyc(); cyc(); cyc();
    look();
    chk("pre_rst_buffered", rp[0] - exp_idx[0], 32'd4);
    adv();
    rrst[0] = 1'b1;
    cyc();
    rrst[0] = 1'b0;
    m_ready[0] = 1'b1;
    look();
    chk("post_rst_valid", {31'd0, m_valid[0]}, 32'd0);
    chk("post_rst_count", {16'd0, rd_count[0]}, 32'd0);
    adv();
    n = 0;
    while (exp_idx[0] != 48 && n < 40) begin
      cyc();
      n++;
    end
    look();
    chk("post_rst_drained", exp_idx[0], 32'd48);
    chk("post_rst_idle", {31'd0, idle[0]}, 32'd1);
    adv();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_stream.md
Name: async_fifo_rd_stream

Overview:
Read-side drain engine for async_fifo, sitting on the rclk side opposite the writer.
- Pops words through the FIFO read port (rreq/rdata/rempty).
- Absorbs the FIFO read latency in a 4-entry skid buffer.
- Presents the words as a valid/ready stream to downstream SNN logic at up to one word per rclk cycle.
- Keeps a running count of delivered words.

Parameters:
DSIZE, 8, data width; must match async_fifo DSIZE.
RD_LATENCY, 0, FIFO read latency: 0 = rdata valid in the same cycle as rreq (show-ahead); 1 = rdata valid one cycle after rreq.
COUNT_W, 16, width of the delivered-word counter.

Ports:
rclk  input  1  read-domain clock; all logic on posedge.
rrst  input  1  synchronous, active-high reset.
rreq  output  1  read request to async_fifo.
rempty  input  1  FIFO empty flag (rclk domain).
rdata  input  DSIZE  FIFO read data.
m_valid  output  1  stream data valid.
m_ready  input  1  downstream accept.
m_data  output  DSIZE  stream data.
rd_count  output  COUNT_W  number of words accepted downstream, modulo 2^COUNT_W.
idle  output  1  high when the block holds no data: buffer empty, nothing in flight, rempty=1.

Behaviour:
- One clock and one reset: the single clock is rclk; reset is synchronous and active-high on rrst.
- Reset values (next posedge with rrst=1):
  - Buffer occupancy occ=0 and in-flight count inflight=0.
  - m_valid=0, m_data=0, rd_count=0.
  - rreq=0 combinationally while rrst=1.
  - idle follows its definition.
- Request rule: rreq = !rrst && !rempty && (occ + inflight < 4).
  - rreq depends only on registered state and rempty; there is no path from m_ready.
  - rreq is never high while rempty=1.
- Capture:
  - RD_LATENCY=0: rdata is written into the buffer tail at the same posedge where rreq=1.
  - RD_LATENCY=1: a single in-flight flag is set on rreq. rdata is written into the buffer at the following posedge, and inflight is cleared there unless a new rreq is issued.
- Buffer: 4-entry FIFO with 2-bit head/tail pointers that wrap 3->0; occ is 0..4.
  - m_valid = (occ != 0); m_data = head entry.
  - m_data is held stable while m_valid=1 and m_ready=0.
- Pop: on m_valid && m_ready at posedge, the head advances and rd_count increments, wrapping to 0 at 2^COUNT_W.
- Simultaneous capture and pop in one cycle: occ is unchanged and both pointers advance. Legal at occ=4 only when the capture is already in flight; the request rule guarantees no overflow.
- Latency from the rreq cycle N to the first m_valid=1:
  - RD_LATENCY=0: m_valid=1 in N+1.
  - RD_LATENCY=1: m_valid=1 in N+2.
- Throughput: with m_ready held high, one word per cycle is sustained for both RD_LATENCY values.
- Ordering: words leave in FIFO order, with no loss or duplication outside reset.
- Reset mid-operation:
  - Buffered and in-flight words are discarded. The FIFO read pointer has already advanced past them, so those words are lost by design.
  - rd_count returns to 0.
- m_ready while m_valid=0 is ignored.
- idle = (occ==0) && (inflight==0) && rempty.

Test Plan:
1. DSIZE=8, RD_LATENCY=0, m_ready=1; writer pushes 1..16 into async_fifo (wclk 10, rclk 40) -> m_data emits 1..16 in order, one per m_valid beat; rd_count=16; rreq never high while rempty=1; idle=1 at end.
2. Backpressure: as scenario 1 but m_ready=0 -> occ reaches 4, rreq drops, m_data holds 1. Then raise m_ready -> 1..16 delivered with no gap, duplicate, or loss; rd_count=16.
3. RD_LATENCY=1 with the FIFO read modelled as registered; pushes 1..16 -> first m_valid 2 cycles after the first rreq; sustained 1 word/cycle with m_ready=1; output 1..16.
4. Toggle m_ready every cycle while the FIFO stays non-empty -> occ never exceeds 4, no word dropped, rd_count matches the number of handshakes.
5. Assert rrst for 1 cycle after 5 words are delivered, with words still buffered -> next cycle m_valid=0, rd_count=0, rreq=0. After release, remaining FIFO words stream correctly; discarded buffered words are not re-emitted.
6. COUNT_W=4, 17 words delivered -> rd_count wraps and reads 1.
